nonce_search_engine: RTL and testbench

//  Responder side of the miner stimulus interface. Accepts target/num_entradas/block header

---
 rtl/miner_pkg.sv | 28 ++
 rtl/nonce_search_engine_if.sv | 28 ++
 rtl/micro_hash.sv | 58 +++++
 rtl/nonce_search_engine.sv | 145 ++++++++++++++
 tb/tb_nonce_search_engine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// Shared types, widths and the acceptance test for the nonce search engine.
package miner_pkg;

  localparam int unsigned HASH_W = 24;
  localparam int unsigned HDR_W  = 96;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_HASH   = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    HASH   = ST_HASH,
    CHECK  = ST_CHECK,
    REPORT = ST_REPORT,
    DONE   = ST_DONE
  } state_t;

  // Only the upper two hash bytes take part in the threshold test.
  function automatic logic hash_ok(input logic [HASH_W-1:8] hash, input logic [7:0] target);
    return (hash[23:16] < target) && (hash[15:8] < target);
  endfunction

endpackage

// File: rtl/nonce_search_engine_if.sv
// Request/result bundle between the stimulus driver (master) and the search engine (slave).
interface nonce_search_engine_if
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_W = 32
);

  logic                start;
  logic [1:0]          num_entradas;
  logic [7:0]          target;
  logic [HDR_W-1:0]    bloque_in;
  logic [HASH_W-1:0]   bounty_out;
  logic [NONCE_W-1:0]  nonce_valido_out;
  logic                nonce_valid;
  logic                fin;
  logic                busy;

  modport master (
    output start, num_entradas, target, bloque_in,
    input  bounty_out, nonce_valido_out, nonce_valid, fin, busy
  );

  modport slave (
    input  start, num_entradas, target, bloque_in,
    output bounty_out, nonce_valido_out, nonce_valid, fin, busy
  );

endinterface

// File: rtl/micro_hash.sv
// Multi-cycle 128->24 bit hash core: folds din on start, then one mixing round per cycle.
module micro_hash #(
  parameter int unsigned HASH_LAT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] din,
  output logic         done,
  output logic [23:0]  hash
);

  localparam int unsigned CNT_W = (HASH_LAT > 1) ? $clog2(HASH_LAT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [23:0]      r_hash;

  function automatic logic [23:0] hash_fold(input logic [127:0] d);
    logic [143:0] w_pad;
    logic [23:0]  h;
    w_pad = {16'h0000, d};
    h     = 24'hA5C35A;
    for (int unsigned i = 0; i < 6; i++) begin
      h = h ^ w_pad[i*24 +: 24];
      h = {h[18:0], h[23:19]} + 24'h3779B9;
    end
    return h;
  endfunction

  function automatic logic [23:0] hash_round(input logic [23:0] h);
    return (h ^ {h[10:0], h[23:11]}) + 24'h9E3779;
  endfunction

  // HASH_LAT-1 rounds run after the fold; done is asserted in the HASH_LAT-th cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_hash <= '0;
    end else if (start) begin
      r_hash <= hash_fold(din);
      r_cnt  <= CNT_W'(HASH_LAT - 1);
      r_run  <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_hash <= hash_round(r_hash);
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign done = r_run && (r_cnt == '0);
  assign hash = r_hash;

endmodule

// File: rtl/nonce_search_engine.sv
// Sweeps nonces through micro_hash until num_entradas+1 hashes pass the target, then raises fin.
// NONCE_LIMIT_EN: stop at MAX_NONCE instead of the all-ones nonce and expose agotado.
module nonce_search_engine
  import miner_pkg::*;
#(
  parameter int unsigned HASH_LAT = 8,
  parameter int unsigned NONCE_W  = 32
`ifdef NONCE_LIMIT_EN
  , parameter logic [NONCE_W-1:0] MAX_NONCE = 'hFFFF
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  nonce_search_engine_if.slave   bus
`ifdef NONCE_LIMIT_EN
  , output logic                 agotado
`endif
);

`ifdef NONCE_LIMIT_EN
  localparam logic [NONCE_W-1:0] LAST_NONCE = MAX_NONCE;
`else
  localparam logic [NONCE_W-1:0] LAST_NONCE = '1;
`endif

  state_t              r_state;
  logic [HDR_W-1:0]    r_bloque;
  logic [7:0]          r_target;
  logic [1:0]          r_num;
  logic [NONCE_W-1:0]  r_nonce;
  logic [2:0]          r_found;
  logic                r_core_start;
  logic [HASH_W-1:0]   r_bounty;
  logic [NONCE_W-1:0]  r_nonce_out;
  logic                r_valid;
  logic                r_fin;
  logic                r_agotado;

  logic                w_core_done;
  logic [HASH_W-1:0]   w_core_hash;
  logic                w_last;
  logic                w_enough;

  micro_hash #(
    .HASH_LAT (HASH_LAT)
  ) u_hash (
    .clk   (clk),
    .reset (reset),
    .start (r_core_start),
    .din   ({r_bloque, 32'(r_nonce)}),
    .done  (w_core_done),
    .hash  (w_core_hash)
  );

  assign w_last   = (r_nonce == LAST_NONCE);
  assign w_enough = (r_found == ({1'b0, r_num} + 3'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bloque     <= '0;
      r_target     <= '0;
      r_num        <= '0;
      r_nonce      <= '0;
      r_found      <= '0;
      r_core_start <= 1'b0;
      r_bounty     <= '0;
      r_nonce_out  <= '0;
      r_valid      <= 1'b0;
      r_fin        <= 1'b0;
      r_agotado    <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_valid      <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // Request fields are captured with the accepted start; later changes are ignored.
          if (bus.start) begin
            r_state   <= LOAD;
            r_bloque  <= bus.bloque_in;
            r_target  <= bus.target;
            r_num     <= bus.num_entradas;
            r_nonce   <= '0;
            r_found   <= '0;
            r_fin     <= 1'b0;
            r_agotado <= 1'b0;
          end
        end
        LOAD: begin
          r_state      <= HASH;
          r_core_start <= 1'b1;
        end
        HASH: begin
          if (w_core_done) r_state <= CHECK;
        end
        CHECK: begin
          if (hash_ok(w_core_hash[HASH_W-1:8], r_target)) begin
            r_state     <= REPORT;
            r_valid     <= 1'b1;
            r_bounty    <= w_core_hash;
            r_nonce_out <= r_nonce;
            r_found     <= r_found + 3'd1;
          end else if (w_last) begin
            r_state   <= DONE;
            r_fin     <= 1'b1;
            r_agotado <= 1'b1;
          end else begin
            r_state      <= HASH;
            r_nonce      <= r_nonce + NONCE_W'(1);
            r_core_start <= 1'b1;
          end
        end
        REPORT: begin
          if (w_enough) begin
            r_state <= DONE;
            r_fin   <= 1'b1;
          end else if (w_last) begin
            r_state   <= DONE;
            r_fin     <= 1'b1;
            r_agotado <= 1'b1;
          end else begin
            r_state      <= HASH;
            r_nonce      <= r_nonce + NONCE_W'(1);
            r_core_start <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bounty_out       = r_bounty;
  assign bus.nonce_valido_out = r_nonce_out;
  assign bus.nonce_valid      = r_valid;
  assign bus.fin              = r_fin;
  assign bus.busy             = (r_state != IDLE) && (r_state != DONE);

`ifdef NONCE_LIMIT_EN
  assign agotado = r_agotado;
`else
  logic w_unused_agotado;
  assign w_unused_agotado = r_agotado;
`endif

endmodule

// File: tb/tb_nonce_search_engine.sv
// Scoreboard bench: a reference search predicts every accepted nonce/hash and the fin latency.
module tb_nonce_search_engine;

  localparam int unsigned HASH_LAT = 8;
`ifdef NONCE_LIMIT_EN
  localparam int CAP = 16;
`else
  localparam int CAP = 4096;
`endif

  typedef struct {
    logic [31:0] nonce;
    logic [23:0] hash;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          pulse_cnt = 0;
  logic [31:0] exp_last_n = '0;
  logic [23:0] exp_last_h = '0;
  logic        exp_exh = 1'b0;
`ifdef NONCE_LIMIT_EN
  logic        agotado;
`endif

  always #5 clk = ~clk;

  nonce_search_engine_if #(.NONCE_W(32)) bus ();

  nonce_search_engine #(
    .HASH_LAT (HASH_LAT),
    .NONCE_W  (32)
`ifdef NONCE_LIMIT_EN
    , .MAX_NONCE (32'd15)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef NONCE_LIMIT_EN
    , .agotado (agotado)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_hash(input logic [95:0] blk, input logic [31:0] n);
    logic [143:0] d;
    logic [23:0]  h;
    d = {16'h0000, blk, n};
    h = 24'hA5C35A;
    for (int i = 0; i < 6; i++) begin
      h = h ^ d[i*24 +: 24];
      h = {h[18:0], h[23:19]} + 24'h3779B9;
    end
    for (int r = 1; r < int'(HASH_LAT); r++) h = (h ^ {h[10:0], h[23:11]}) + 24'h9E3779;
    return h;
  endfunction

  // Fills the scoreboard and returns the expected cycle count from start acceptance to fin.
  task automatic predict(input logic [7:0] tgt, input logic [1:0] num, input logic [95:0] blk,
                         output int cyc);
    int          need;
    int          found;
    logic [23:0] h;
    exp_t        e;
    need  = int'(num) + 1;
    found = 0;
    cyc   = 1;
    for (int n = 0; n < CAP && found < need; n++) begin
      h = ref_hash(blk, n);
      if ((h[23:16] < tgt) && (h[15:8] < tgt)) begin
        e.nonce = n;
        e.hash  = h;
        q.push_back(e);
        exp_last_n = n;
        exp_last_h = h;
        found++;
        cyc += int'(HASH_LAT) + 3;
      end else begin
        cyc += int'(HASH_LAT) + 2;
      end
    end
    exp_exh = (found < need);
  endtask

  task automatic run_search(input logic [7:0] tgt, input logic [1:0] num, input logic [95:0] blk,
                            input bit disturb, output int cyc);
    int cyc_exp;
    int pulses0;
    predict(tgt, num, blk, cyc_exp);
    pulses0 = pulse_cnt;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.target       = tgt;
    bus.num_entradas = num;
    bus.bloque_in    = blk;
    @(negedge clk);
    bus.start = 1'b0;
    chk("fin_clear_on_load", bus.fin, 1'b0);
    chk("busy_in_load", bus.busy, 1'b1);
`ifdef NONCE_LIMIT_EN
    chk("agotado_clear_on_load", agotado, 1'b0);
`endif
    cyc = 0;
    while (bus.fin !== 1'b1 && cyc < cyc_exp + 50) begin
      if (disturb && bus.busy === 1'b1 && (cyc % 5) == 2) begin
        bus.start     = 1'b1;
        bus.target    = 8'($urandom);
        bus.bloque_in = {$urandom, $urandom, $urandom};
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("fin_latency", cyc, cyc_exp);
    chk("fin_level", bus.fin, 1'b1);
    chk("busy_done", bus.busy, 1'b0);
    chk("pulse_count", pulse_cnt - pulses0, q.size() == 0 ? int'(num) + 1 - int'(exp_exh) : -1);
    chk("scoreboard_drained", q.size(), 0);
    chk("nonce_out_held", bus.nonce_valido_out, exp_last_n);
    chk("bounty_out_held", bus.bounty_out, exp_last_h);
`ifdef NONCE_LIMIT_EN
    chk("agotado", agotado, exp_exh);
`endif
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.nonce_valid === 1'b1) begin
      pulse_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_pulse", bus.nonce_valid, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("nonce", bus.nonce_valido_out, e.nonce);
        chk("bounty", bus.bounty_out, e.hash);
        chk("busy_in_report", bus.busy, 1'b1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int c;
    bus.start        = 1'b0;
    bus.num_entradas = '0;
    bus.target       = '0;
    bus.bloque_in    = '0;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bounty", bus.bounty_out, 0);
    chk("rst_nonce", bus.nonce_valido_out, 0);
    chk("rst_valid", bus.nonce_valid, 0);
    chk("rst_fin", bus.fin, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;

`ifdef NONCE_LIMIT_EN
    chk("rst_agotado", agotado, 0);
    run_search(8'h00, 2'd3, 96'h0123_4567_89AB_CDEF_0F1E_2D3C, 1'b0, c);
`endif

    run_search(8'hFF, 2'd0, 96'hDEAD_BEEF_0000_1111_2222_3333, 1'b0, c1);
    run_search(8'h40, 2'd3, 96'hCAFE_F00D_5555_AAAA_1234_5678, 1'b0, c);

    // Reset in the middle of a hash, asserted between clock edges.
    @(negedge clk);
    bus.start        = 1'b1;
    bus.target       = 8'hFF;
    bus.num_entradas = 2'd0;
    bus.bloque_in    = 96'hDEAD_BEEF_0000_1111_2222_3333;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", bus.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_bounty", bus.bounty_out, 0);
    chk("async_rst_nonce", bus.nonce_valido_out, 0);
    chk("async_rst_valid", bus.nonce_valid, 0);
    chk("async_rst_fin", bus.fin, 0);
    chk("async_rst_busy", bus.busy, 0);
    q.delete();
    exp_last_n = '0;
    exp_last_h = '0;
    @(negedge clk);
    reset = 1'b0;
    run_search(8'hFF, 2'd0, 96'hDEAD_BEEF_0000_1111_2222_3333, 1'b0, c);
    chk("restart_latency", c, c1);

    run_search(8'h40, 2'd1, 96'h1357_9BDF_2468_ACE0_FFFF_0000, 1'b1, c);
    run_search(8'h80, 2'd2, 96'h0BAD_C0DE_7777_8888_9999_AAAA, 1'b0, c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
